tile_hit_judge: RTL

Producer side of the score `increment` interface. The block judges each lane key press against the game's hit-zone occupancy and issues the 2-cycle `increment` pulse that advances the score register by exactly one. It also counts misses, including presses on empty lanes and tiles that escape unplayed, and declares game over. It sits between the pushbuttons and game logic on the input side, and the score register and game FSM on the output side.

---
 rtl/tile_hit_judge.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/tile_hit_judge.sv
// Lane press judge: decides hit or miss for each accepted key press, issues the
// two-cycle score increment, tracks misses and escaped tiles, and declares game over.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  IDLE   | waiting for startn; outputs quiet, lives = MAX_MISSES
//  PLAY   | judging escapes and key presses
//  HIT1   | first increment cycle (tile_clear pulses on entry)
//  HIT2   | second increment cycle
//  MISS   | miss pulse cycle; lives already reduced
//  OVER   | game_over high until startn
module tile_hit_judge #(
    parameter int LANES          = 4,
    parameter int MAX_MISSES     = 3,
    parameter int LOCKOUT_CYCLES = 500000
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             startn,
    input  logic [LANES-1:0] key_n,
    input  logic [LANES-1:0] tile_in_zone,
    input  logic [LANES-1:0] tile_escape,
    output logic             increment,
    output logic [LANES-1:0] tile_clear,
    output logic             miss,
    output logic [2:0]       lives,
    output logic             game_over,
    output logic             playing
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PLAY = 3'd1;
    localparam logic [2:0] S_HIT1 = 3'd2;
    localparam logic [2:0] S_HIT2 = 3'd3;
    localparam logic [2:0] S_MISS = 3'd4;
    localparam logic [2:0] S_OVER = 3'd5;

    localparam logic [2:0]  MAX_M     = 3'(MAX_MISSES);
    localparam logic [19:0] LOCK_LOAD = 20'(LOCKOUT_CYCLES);

    logic [2:0]       state;
    logic [LANES-1:0] key_s1;
    logic [LANES-1:0] key_s2;
    logic [LANES-1:0] key_prev;
    logic [LANES-1:0] press_evt;
    logic [LANES-1:0] press_oh;
    logic [19:0]      lockout;
    logic [2:0]       pending;
    logic [2:0]       misses;
    logic [2:0]       misses_inc;
    logic             service;
    logic             accept;
    logic             hit;
    logic             esc_any;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            key_s1   <= '1;
            key_s2   <= '1;
            key_prev <= '1;
        end else begin
            key_s1   <= key_n;
            key_s2   <= key_s1;
            key_prev <= key_s2;
        end
    end

    // Falling edge of the synced key; the lowest lane wins by isolating the lowest set bit.
    assign press_evt  = ~key_s2 & key_prev;
    assign press_oh   = press_evt & (~press_evt + LANES'(1));
    assign esc_any    = |tile_escape;
    assign service    = (state == S_PLAY) && startn && (pending != 3'd0);
    assign accept     = (state == S_PLAY) && startn && (pending == 3'd0) &&
                        (lockout == 20'd0) && (|press_oh);
    assign hit        = |(press_oh & tile_in_zone);
    assign misses_inc = misses + 3'd1;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pending <= 3'd0;
        end else if ((state == S_IDLE) || !startn) begin
            pending <= 3'd0;
        end else if (service && !esc_any) begin
            pending <= pending - 3'd1;
        end else if (esc_any && !service && (pending != 3'd7)) begin
            pending <= pending + 3'd1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lockout <= 20'd0;
        end else if ((state == S_IDLE) && !startn) begin
            lockout <= 20'd0;
        end else if (accept) begin
            lockout <= LOCK_LOAD;
        end else if (lockout != 20'd0) begin
            lockout <= lockout - 20'd1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            misses     <= 3'd0;
            increment  <= 1'b0;
            tile_clear <= '0;
            miss       <= 1'b0;
            lives      <= MAX_M;
            game_over  <= 1'b0;
            playing    <= 1'b0;
        end else begin
            increment  <= 1'b0;
            tile_clear <= '0;
            miss       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!startn) begin
                        state     <= S_PLAY;
                        misses    <= 3'd0;
                        lives     <= MAX_M;
                        game_over <= 1'b0;
                        playing   <= 1'b1;
                    end
                end
                S_PLAY, S_HIT1, S_HIT2, S_MISS: begin
                    if (!startn) begin
                        state     <= S_IDLE;
                        misses    <= 3'd0;
                        lives     <= MAX_M;
                        game_over <= 1'b0;
                        playing   <= 1'b0;
                    end else if (state == S_PLAY) begin
                        // Escapes outrank presses; a press seen alongside one is dropped.
                        if (service || (accept && !hit)) begin
                            state     <= S_MISS;
                            miss      <= 1'b1;
                            misses    <= misses_inc;
                            lives     <= MAX_M - misses_inc;
                            game_over <= (misses_inc == MAX_M);
                        end else if (accept) begin
                            state      <= S_HIT1;
                            tile_clear <= press_oh;
                            increment  <= 1'b1;
                        end
                    end else if (state == S_HIT1) begin
                        state     <= S_HIT2;
                        increment <= 1'b1;
                    end else if (state == S_HIT2) begin
                        state <= S_PLAY;
                    end else begin
                        if (misses == MAX_M) begin
                            state   <= S_OVER;
                            playing <= 1'b0;
                        end else begin
                            state <= S_PLAY;
                        end
                    end
                end
                S_OVER: begin
                    if (!startn) begin
                        state     <= S_IDLE;
                        misses    <= 3'd0;
                        lives     <= MAX_M;
                        game_over <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    playing <= 1'b0;
                end
            endcase
        end
    end

endmodule
